// File: rtl/ic9_env_param_encoder.sv
// ic9_env_param_encoder: serial normaliser that turns a 19-bit linear envelope
// increment into the IC9 parameter ROM word (inverted-high mantissa) and shift code.
// The encoder shifts one bit per cycle until the hidden bit reaches sr[18] or
// the shift code reaches 0. The result is then held in DONE until the consumer accepts it.
// Optional feature macro: IC9_ENV_ENC_ROUND_EN. When it is defined, PACK rounds
// to nearest using sr[4]. When it is undefined, bits below sr[5] are truncated
// and out_sat is tied to 0.
module ic9_env_param_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_rom,
    output logic [3:0]  out_bus,
    output logic        out_uflow,
    output logic        out_sat
);

    localparam int unsigned VAL_W  = 19;
    localparam int unsigned MANT_W = 13;
    localparam int unsigned EXP_W  = 4;
    localparam logic [EXP_W-1:0]  E_MAX    = EXP_W'(11);
    localparam logic [MANT_W-1:0] ROM_ZERO = MANT_W'(13'h1FE0);

    typedef enum logic [1:0] {IDLE, SCAN, PACK, DONE} state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   sr_q;
    logic [EXP_W-1:0]   e_q;
    logic               in_ready_d, out_valid_d;
    logic [MANT_W-1:0]  pack_m;
    logic [EXP_W-1:0]   pack_e;
    logic               pack_uflow;
    logic [MANT_W-1:0]  pack_rom;
    logic               scan_stop;
`ifdef IC9_ENV_ENC_ROUND_EN
    logic               pack_sat;
`endif

    assign scan_stop = sr_q[VAL_W-1] || (e_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) state_d = SCAN;
            SCAN: if (scan_stop)            state_d = PACK;
            PACK:                           state_d = DONE;
            DONE: if (out_ready)            state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state, then registered
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (state_d == IDLE) in_ready_d  = 1'b1;
        if (state_d == DONE) out_valid_d = 1'b1;
    end

    // Mantissa/exponent extraction, underflow and optional round-to-nearest
    always_comb begin
        pack_m     = sr_q[VAL_W-2:5];
        pack_e     = e_q;
        pack_uflow = 1'b0;
`ifdef IC9_ENV_ENC_ROUND_EN
        pack_sat   = 1'b0;
`endif
        if (!sr_q[VAL_W-1]) begin
            pack_m     = '0;
            pack_e     = '0;
            pack_uflow = 1'b1;
        end
`ifdef IC9_ENV_ENC_ROUND_EN
        else if (sr_q[4]) begin
            if (&pack_m) begin
                if (e_q == E_MAX) begin
                    pack_sat = 1'b1;
                end else begin
                    pack_m = '0;
                    pack_e = EXP_W'(e_q + EXP_W'(1));
                end
            end else begin
                pack_m = MANT_W'(pack_m + MANT_W'(1));
            end
        end
`endif
        pack_rom = {~pack_m[MANT_W-1:5], pack_m[4:0]};
    end

    // Datapath: shift register, shift code, handshake flags and result holding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q      <= '0;
            e_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rom   <= ROM_ZERO;
            out_bus   <= '0;
            out_uflow <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sr_q <= in_value;
                        e_q  <= E_MAX;
                    end
                end
                SCAN: begin
                    if (!scan_stop) begin
                        sr_q <= VAL_W'(sr_q << 1);
                        e_q  <= EXP_W'(e_q - EXP_W'(1));
                    end
                end
                PACK: begin
                    out_rom   <= pack_rom;
                    out_bus   <= pack_e;
                    out_uflow <= pack_uflow;
                end
                default: ;
            endcase
        end
    end

`ifdef IC9_ENV_ENC_ROUND_EN
    // Saturation flag captured alongside the result
    always_ff @(posedge clk) begin
        if (!rst_n)                out_sat <= 1'b0;
        else if (state_q == PACK)  out_sat <= pack_sat;
    end
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: doc/ic9_env_param_encoder.md
IC9_ENV_PARAM_ENCODER -- requirements
Module: ic9_env_param_encoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_value is offered.
REQ-005 in_ready  output  1  encoder idle and able to accept.
REQ-006 in_value  input  19  linear envelope increment to encode (adder operand domain).
REQ-007 out_valid  output  1  encoded result held stable.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 out_rom  output  13  parameter ROM word: rom[12:5] = ~M[12:5], rom[4:0] = M[4:0].
REQ-010 out_bus  output  4  shift code E, 0..11, as driven on param_bus.
REQ-011 out_uflow  output  1  in_value below 0x00080, not representable.
REQ-012 out_sat  output  1  rounding overflowed the largest code.

Function
REQ-013 The block SHALL invert the IC9 decode V = ({1,M[12:0]} << E) >> 6, choosing the largest E with hidden bit at position 7+E.
REQ-014 The block SHALL implement FSM states IDLE, SCAN, PACK, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, load sr <= in_value and e <= 11, then go to SCAN.
REQ-016 SCAN: if sr[18]=1 or e=0, go to PACK; else sr <= sr<<1 and e <= e-1, one bit per cycle.
REQ-017 PACK: M = sr[17:5]; if sr[18]=0, force M=0, E=0 and uflow=1; register outputs, then go to DONE.
REQ-018 DONE: out_valid=1; outputs SHALL hold stable until out_ready=1, then return to IDLE.
REQ-019 Handshake latency SHALL be exactly 2+(11-E) cycles from input handshake to out_valid, i.e. 2 to 13 cycles.
REQ-020 in_ready SHALL be 0 in SCAN, PACK and DONE; no input is accepted before the DONE handshake completes.
REQ-021 out_ready asserted outside DONE SHALL have no effect.
REQ-022 Bits below sr[5] SHALL be truncated unless the rounding feature is enabled.
REQ-023 in_value=0 SHALL produce uflow=1, out_rom=0x1FE0, out_bus=0.

Reset
REQ-024 On rst_n=0 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-SCAN or in DONE; the pending result is discarded.
REQ-025 Reset values: in_ready=1 from the first cycle after reset; out_valid=0, out_rom=0x1FE0, out_bus=0, out_uflow=0, out_sat=0; internal sr=0, e=0.

Configuration
REQ-026 Macro IC9_ENV_ENC_ROUND_EN present: PACK SHALL round to nearest.
- If sr[4]=1: M=M+1.
- If M wraps from 0x1FFF: M=0 and E=E+1.
- If E was 11: M=0x1FFF, E=11, sat=1.
- Latency is unchanged.
REQ-027 Macro absent: truncation only, and out_sat SHALL be tied to 0.

Verification
REQ-028 in_value=0x40000 -> out_bus=11, out_rom=0x1FE0, uflow=0; out_valid 2 cycles after the handshake.
REQ-029 in_value=0x00080 -> out_bus=0, out_rom=0x1FE0; out_valid 13 cycles after the handshake.
REQ-030 in_value=0x00123 -> out_bus=1, M=0x0460, out_rom=0x1B80; latency 12 cycles.
REQ-031 in_value=0x0007F -> uflow=1, out_bus=0, out_rom=0x1FE0.
REQ-032 in_value=0x7FFFF -> out_bus=11, out_rom=0x001F.
- With IC9_ENV_ENC_ROUND_EN: sat=1.
- Without it: sat=0.
REQ-033 Backpressure and reset:
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
- Pulse rst_n=0 mid-SCAN -> IDLE next cycle, out_valid never asserted.
